// File: rtl/image_sequencer.sv
// image_sequencer: rotates between pattern generators with frame-synchronous hold, fade-out and fade-in.
module image_sequencer #(
  parameter int NUM_IMAGES  = 2,
  parameter int HOLD_FRAMES = 600,
  parameter int FADE_DIV    = 1,
  localparam int SW = NUM_IMAGES > 1 ? $clog2(NUM_IMAGES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    skip,
  input  logic [4*NUM_IMAGES-1:0] img_r,
  input  logic [4*NUM_IMAGES-1:0] img_g,
  input  logic [4*NUM_IMAGES-1:0] img_b,
  output logic [31:0]             frame,
  output logic [SW-1:0]           select,
  output logic                    fading,
  output logic [3:0]              r,
  output logic [3:0]              g,
  output logic [3:0]              b
);
  localparam int HW = HOLD_FRAMES > 1 ? $clog2(HOLD_FRAMES) : 1;
  localparam int DW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  typedef enum logic [1:0] {SHOW, FADE_OUT, FADE_IN} state_t;
  state_t state, state_n;
  logic [4:0] level, level_n;
  logic [SW-1:0] select_n;
  logic [HW-1:0] hold, hold_n;
  logic [DW-1:0] div, div_n;
  logic [3:0] cr, cg, cb;
  logic step;
  always_comb begin
    state_n  = state;
    level_n  = level;
    select_n = select;
    hold_n   = hold;
    div_n    = div;
    step     = div == DW'(FADE_DIV - 1);
    cr = '0;
    cg = '0;
    cb = '0;
    for (int k = 0; k < NUM_IMAGES; k++)
      if (select == SW'(k)) begin
        cr = img_r[4*k +: 4];
        cg = img_g[4*k +: 4];
        cb = img_b[4*k +: 4];
      end
    if (frame_tick)
      case (state)
        SHOW:
          if (skip || hold == HW'(HOLD_FRAMES - 1)) begin
            state_n = FADE_OUT;
            hold_n  = '0;
            div_n   = '0;
          end else hold_n = hold + 1'b1;
        FADE_OUT:
          if (!step) div_n = div + 1'b1;
          else begin
            div_n   = '0;
            level_n = level - 1'b1;
            if (level == 5'd1) begin
              state_n  = FADE_IN;
              select_n = select == SW'(NUM_IMAGES - 1) ? '0 : select + 1'b1;
            end
          end
        default:
          if (!step) div_n = div + 1'b1;
          else begin
            div_n   = '0;
            level_n = level + 1'b1;
            if (level == 5'd15) begin
              state_n = SHOW;
              hold_n  = '0;
            end
          end
      endcase
  end
  // Colour scaling uses the registered select/level, so it lags state by one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SHOW;
      level  <= 5'd16;
      select <= '0;
      hold   <= '0;
      div    <= '0;
      frame  <= '0;
      fading <= 1'b0;
      r <= '0;
      g <= '0;
      b <= '0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      select <= select_n;
      hold   <= hold_n;
      div    <= div_n;
      fading <= state_n != SHOW;
      if (frame_tick) frame <= frame + 1'b1;
      r <= 4'(({4'b0, cr} * {3'b0, level}) >> 4);
      g <= 4'(({4'b0, cg} * {3'b0, level}) >> 4);
      b <= 4'(({4'b0, cb} * {3'b0, level}) >> 4);
    end
  end
endmodule

// File: tb/tb_image_sequencer.sv
// tb_image_sequencer: directed stimulus pushing expectations; a negedge monitor pops and compares.
module tb_image_sequencer;
  logic clk = 0, rst = 1, ft = 0, skip = 0;
  logic [7:0]  ir2 = {4'h5, 4'hA}, ig2 = {4'hC, 4'hF}, ib2 = {4'h9, 4'h3};
  logic [11:0] ir3 = {4'h7, 4'h5, 4'hA}, ig3 = {4'h1, 4'hC, 4'hF}, ib3 = {4'hE, 4'h9, 4'h3};
  logic [31:0] fr0, fr1, fr2;
  logic [0:0] s0, s2;
  logic [1:0] s1;
  logic f0, f1, f2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [3:0] gr [3] = '{4'hA, 4'h5, 4'h7};
  logic [3:0] gg [3] = '{4'hF, 4'hC, 4'h1};
  logic [3:0] gb [3] = '{4'h3, 4'h9, 4'hE};
  typedef struct packed {
    logic [1:0]  dut;
    logic [3:0]  r, g, b;
    logic [1:0]  sel;
    logic        fad;
    logic [31:0] frame;
  } exp_t;
  exp_t q[$];
  string nq[$];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  image_sequencer #(.NUM_IMAGES(2), .HOLD_FRAMES(4), .FADE_DIV(1)) d0 (
    .clk(clk), .rst(rst), .frame_tick(ft), .skip(skip), .img_r(ir2), .img_g(ig2), .img_b(ib2),
    .frame(fr0), .select(s0), .fading(f0), .r(r0), .g(g0), .b(b0));
  image_sequencer #(.NUM_IMAGES(3), .HOLD_FRAMES(2), .FADE_DIV(1)) d1 (
    .clk(clk), .rst(rst), .frame_tick(ft), .skip(skip), .img_r(ir3), .img_g(ig3), .img_b(ib3),
    .frame(fr1), .select(s1), .fading(f1), .r(r1), .g(g1), .b(b1));
  image_sequencer #(.NUM_IMAGES(2), .HOLD_FRAMES(600), .FADE_DIV(3)) d2 (
    .clk(clk), .rst(rst), .frame_tick(ft), .skip(skip), .img_r(ir2), .img_g(ig2), .img_b(ib2),
    .frame(fr2), .select(s2), .fading(f2), .r(r2), .g(g2), .b(b2));

  function automatic logic [3:0] sc(input logic [3:0] v, input int l);
    return 4'((int'(v) * l) >> 4);
  endfunction

  task automatic ex(input string n, input int d, input int lvl, input int s, input logic fad, input int frm);
    exp_t e;
    e.dut = 2'(d);
    e.r = sc(gr[s], lvl);
    e.g = sc(gg[s], lvl);
    e.b = sc(gb[s], lvl);
    e.sel = 2'(s);
    e.fad = fad;
    e.frame = 32'(frm);
    q.push_back(e);
    nq.push_back(n);
  endtask

  // one frame_tick pulse, then one idle clk so r/g/b reflect the new level
  task automatic tk(input int n, input logic s);
    skip = s;
    repeat (n) begin
      @(posedge clk) #1 ft = 1;
      @(posedge clk) #1 ft = 0;
      @(posedge clk) #1;
    end
    skip = 0;
  endtask

  task automatic rst_all();
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1 rst = 0;
    @(posedge clk) #1;
  endtask

  initial forever begin
    exp_t e;
    string n;
    logic [3:0] ar, ag, ab;
    logic [1:0] as;
    logic af;
    logic [31:0] afr;
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      n = nq.pop_front();
      case (e.dut)
        2'd0: begin ar = r0; ag = g0; ab = b0; as = {1'b0, s0}; af = f0; afr = fr0; end
        2'd1: begin ar = r1; ag = g1; ab = b1; as = s1; af = f1; afr = fr1; end
        default: begin ar = r2; ag = g2; ab = b2; as = {1'b0, s2}; af = f2; afr = fr2; end
      endcase
      checks++;
      if ({ar, ag, ab, as, af, afr} !== {e.r, e.g, e.b, e.sel, e.fad, e.frame}) begin
        errors++;
        $display("FAIL %s: got r=%h g=%h b=%h sel=%0d fading=%b frame=%0d, expected r=%h g=%h b=%h sel=%0d fading=%b frame=%0d",
                 n, ar, ag, ab, as, af, afr, e.r, e.g, e.b, e.sel, e.fad, e.frame);
      end
    end
  end

  initial begin
    rst = 1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    ex("reset_d0", 0, 0, 0, 0, 0);
    ex("reset_d2", 2, 0, 0, 0, 0);
    rst = 0;
    @(posedge clk) #1;
    ex("passthrough", 0, 16, 0, 0, 0);
    tk(4, 0);  ex("hold_end", 0, 16, 0, 1, 4);
    tk(1, 0);  ex("fade_step1", 0, 15, 0, 1, 5);
    tk(14, 0); ex("fade_lvl1", 0, 1, 0, 1, 19);
    tk(1, 0);  ex("fade_swap", 0, 0, 1, 1, 20);
    tk(7, 1);  ex("skip_in_fadein", 0, 7, 1, 1, 27);
    tk(9, 0);  ex("show_gen1", 0, 16, 1, 0, 36);
    tk(1, 0);  ex("skip_not_queued", 0, 16, 1, 0, 37);
    tk(12, 0); ex("midfade_lvl7", 0, 7, 1, 1, 49);
    @(posedge clk) #1 begin rst = 1; ft = 1; end
    @(posedge clk) #1 begin rst = 0; ft = 0; end
    ex("rst_midfade", 0, 0, 0, 0, 0);
    @(posedge clk) #1;
    ex("rst_pass", 0, 16, 0, 0, 0);
    tk(1, 0);  ex("rst_tick_ignored", 0, 16, 0, 0, 1);
    rst_all();
    tk(17, 0); ex("rot_17", 1, 1, 0, 1, 17);
    tk(1, 0);  ex("rot_18", 1, 0, 1, 1, 18);
    tk(16, 0); ex("rot_34", 1, 16, 1, 0, 34);
    tk(18, 0); ex("rot_52", 1, 0, 2, 1, 52);
    tk(16, 0); ex("rot_68", 1, 16, 2, 0, 68);
    tk(18, 0); ex("rot_86", 1, 0, 0, 1, 86);
    rst_all();
    tk(1, 0);  ex("div_hold1", 2, 16, 0, 0, 1);
    tk(1, 1);  ex("skip_show", 2, 16, 0, 1, 2);
    tk(2, 0);  ex("div_wait", 2, 16, 0, 1, 4);
    tk(1, 0);  ex("div_step1", 2, 15, 0, 1, 5);
    tk(2, 0);  ex("div_wait2", 2, 15, 0, 1, 7);
    tk(1, 0);  ex("div_step2", 2, 14, 0, 1, 8);
    tk(41, 0); ex("div_lvl1", 2, 1, 0, 1, 49);
    tk(1, 0);  ex("div_swap", 2, 0, 1, 1, 50);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL monitor_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/image_sequencer.md
Name: image_sequencer

Overview:
Schedules which pattern generator drives the VGA colour outputs and supplies the shared frame counter to all generators. Holds each pattern for a programmable number of frames, then fades it out, switches to the next generator and fades that one in. All pattern and brightness changes occur only on frame_tick, i.e. during vertical blanking. Sits between the image generator instances and the VGA output register stage.

Parameters:
NUM_IMAGES, 2, number of generator instances multiplexed (>=1)
HOLD_FRAMES, 600, frames a pattern is shown at full brightness before fading (>=1)
FADE_DIV, 1, frame_ticks per brightness step during fades (>=1)

Ports:
clk  input  1  system/pixel clock
rst  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse once per frame, asserted in vertical blanking
skip  input  1  request early advance; sampled only on frame_tick cycles while in SHOW
img_r  input  4*NUM_IMAGES  red from each generator; generator k occupies bits [4k+3:4k]
img_g  input  4*NUM_IMAGES  green, packed as img_r
img_b  input  4*NUM_IMAGES  blue, packed as img_r
frame  output  32  frame count broadcast to all generators
select  output  max(1,$clog2(NUM_IMAGES))  index of the active generator
fading  output  1  high when state is not SHOW
r  output  4  scaled red
g  output  4  scaled green
b  output  4  scaled blue

Behaviour:
- Reset (rst high at a clk edge): state=SHOW, level=16, select=0, frame=0, hold_cnt=0, div_cnt=0, r/g/b=0, fading=0. Reset takes priority over everything, including a concurrent frame_tick, and aborts any fade in progress.
- frame: increments by 1 on every frame_tick, in every state; wraps 0xFFFFFFFF->0.
- level: 5 bits, range 0..16.
- States: SHOW, FADE_OUT, FADE_IN. Only frame_tick cycles change state, level, select or the counters.
- SHOW, on frame_tick:
  - If skip=1 or hold_cnt==HOLD_FRAMES-1: go to FADE_OUT, hold_cnt=0, div_cnt=0, level unchanged (16).
  - Else: hold_cnt+=1.
- Step qualifier (FADE_OUT and FADE_IN, on frame_tick):
  - If div_cnt==FADE_DIV-1: a step occurs and div_cnt=0.
  - Else: div_cnt+=1 and nothing else changes.
- FADE_OUT, on a step: level-=1. When level goes 1->0 on that step:
  - select advances (select==NUM_IMAGES-1 wraps to 0); NUM_IMAGES=1 keeps select=0.
  - Go to FADE_IN on the same edge.
- FADE_IN, on a step: level+=1. When level goes 15->16: go to SHOW, hold_cnt=0.
- skip is ignored outside SHOW and is not queued.
- Cycle length with FADE_DIV=1: each image lasts HOLD_FRAMES ticks in SHOW, then 16 ticks of FADE_OUT, then 16 ticks of FADE_IN.
- Colour path, registered every clk, one-cycle latency:
  - r <= (img_r[select]*level)>>4, using the registered select and level; g and b identical.
  - Products are 9 bits and are truncated to 4 bits after the shift. level=16 passes the input through exactly; level=0 gives 0.
- fading is a registered decode: 1 in FADE_OUT or FADE_IN.
- Width rules: hold_cnt is wide enough for HOLD_FRAMES-1; div_cnt is wide enough for FADE_DIV-1.
- frame_tick held high for multiple cycles is illegal; behaviour is undefined and is not checked.

Test Plan:
- Reset/passthrough: apply rst, then img_r=0xA for generator 0 with no ticks -> r=0xA one clk after the input; select=0, frame=0, fading=0.
- Hold and fade-out timing (HOLD_FRAMES=4, FADE_DIV=1, NUM_IMAGES=2, img_r0=0xF): 4 ticks -> fading=1, level 16. Next tick -> r=0xF*15>>4=0xE. At the 20th tick -> select=1 and state FADE_IN.
- Full rotation: NUM_IMAGES=3, HOLD_FRAMES=2 -> select steps 0,1,2,0 at ticks 18, 52, 86. frame equals the tick count throughout.
- Skip: in SHOW with hold_cnt=1 of 600, skip=1 on a tick -> FADE_OUT next. skip=1 during FADE_IN -> no effect, level keeps incrementing.
- FADE_DIV=3: during FADE_OUT, level decrements only on every 3rd tick; 48 ticks from 16 down to 0.
- Reset mid-fade: rst while level=7 in FADE_OUT -> next cycle state=SHOW, level=16, select=0, frame=0, r=0; a tick coincident with rst is ignored.
